// File: rtl/fmul_norm.sv
// ---------------------------------------------------------------------------
// fmul_norm -- post-multiplier normalise/round stage of the FP multiply path.
//
// Accepts per-operation metadata in the same cycle the unpacker drives the
// mantissas into the pipelined multiplier, books the completion slot, carries
// the metadata through a latency-matched delay line and, in the cycle the
// truncated product appears on R32/R64/R128, normalises/rounds it and
// registers a packed result.
//
// Latencies (issue to product): single 2, double 3, quad 6.
// Result RDY: issue cycle + 3 / + 4 / + 7.
//
// Ports
//   CLK, RESET         clock, synchronous active-high reset
//   STB / ACK          issue request / issue accepted
//   FMT                0 single, 1 double, 2 quad, 3 reserved (never ACKed)
//   SA, SB             operand signs
//   EA, EB             biased exponents, right-aligned per format
//   ZA, ZB             operand-is-zero flags
//   TAG                opaque id returned on RTAG
//   R32, R64, R128     multiplier product buses (25 / 54 / 114 bits)
//   RDY                one-cycle result-valid pulse
//   RFMT, RTAG, RS, RE result format, tag, sign, biased exponent
//   RM                 fraction without hidden bit, right-aligned, upper 0
//   OVF, UNF           overflow / underflow, valid with RDY
//
// Configuration macro
//   FMUL_NORM_ROUND_EN  defined: round-half-up on the guard bit (with
//                       exponent bump on fraction carry); undefined: plain
//                       truncation.
//
// Handshake: an operation issues on a rising edge where STB and ACK are both
// high. ACK depends only on FMT and the slot map, never on STB, so upstream
// may hold STB and operands until it is accepted.
// ---------------------------------------------------------------------------
module fmul_norm (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         STB,
   output logic         ACK,
   input  logic [1:0]   FMT,
   input  logic         SA,
   input  logic         SB,
   input  logic [14:0]  EA,
   input  logic [14:0]  EB,
   input  logic         ZA,
   input  logic         ZB,
   input  logic [5:0]   TAG,
   input  logic [24:0]  R32,
   input  logic [53:0]  R64,
   input  logic [113:0] R128,
   output logic         RDY,
   output logic [1:0]   RFMT,
   output logic [5:0]   RTAG,
   output logic         RS,
   output logic [14:0]  RE,
   output logic [111:0] RM,
   output logic         OVF,
   output logic         UNF
);

   typedef struct packed {
      logic        valid;
      logic [1:0]  fmt;
      logic        sign;
      logic [16:0] expSum;   // EA+EB-bias, two's complement
      logic        zero;
      logic [5:0]  tag;
   } meta_t;

   logic [6:0]   slotMap;
   logic [6:0]   slotShift;
   logic [6:0]   slotSet;
   logic [2:0]   issueLat;
   logic [16:0]  bias;
   logic         issue;
   meta_t        newMeta;
   meta_t        delayLine [6];
   meta_t        tapMeta;
   logic         tapHit;

   logic         lead;
   logic [111:0] frac;
   logic [111:0] fracOut;
   logic         fracCarry;
   logic [16:0]  emax;
   logic [16:0]  expFinal;
   logic [14:0]  resE;
   logic [111:0] resM;
   logic         resOvf;
   logic         resUnf;

   // ---------------- issue side ----------------
   always_comb begin
      issueLat = 3'd0;
      bias     = 17'd0;
      case (FMT)
         2'd0:    begin issueLat = 3'd2; bias = 17'd127;   end
         2'd1:    begin issueLat = 3'd3; bias = 17'd1023;  end
         2'd2:    begin issueLat = 3'd6; bias = 17'd16383; end
         default: begin issueLat = 3'd0; bias = 17'd0;     end
      endcase
   end

   // Bit k of the shifted map is the completion cycle the new operation
   // would occupy if issued now with latency k.
   assign slotShift = {1'b0, slotMap[6:1]};
   assign ACK       = (FMT != 2'd3) & ~slotShift[issueLat];
   assign issue     = STB & ACK;
   assign slotSet   = issue ? (7'd1 << issueLat) : 7'd0;

   always_comb begin
      newMeta.valid  = issue;
      newMeta.fmt    = FMT;
      newMeta.sign   = SA ^ SB;
      newMeta.expSum = {2'b00, EA} + {2'b00, EB} - bias;
      newMeta.zero   = ZA | ZB;
      newMeta.tag    = TAG;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         slotMap <= '0;
         for (int i = 0; i < 6; i++) delayLine[i] <= '0;
      end else begin
         slotMap      <= slotShift | slotSet;
         delayLine[0] <= newMeta;
         for (int i = 1; i < 6; i++) delayLine[i] <= delayLine[i-1];
      end
   end

   // ---------------- product capture ----------------
   // An operation sits in delayLine[L-1] during its product cycle. The slot
   // map guarantees at most one of these taps is live in any cycle.
   always_comb begin
      tapHit  = 1'b0;
      tapMeta = '0;
      if (delayLine[1].valid && delayLine[1].fmt == 2'd0) begin
         tapHit  = 1'b1;
         tapMeta = delayLine[1];
      end
      if (delayLine[2].valid && delayLine[2].fmt == 2'd1) begin
         tapHit  = 1'b1;
         tapMeta = delayLine[2];
      end
      if (delayLine[5].valid && delayLine[5].fmt == 2'd2) begin
         tapHit  = 1'b1;
         tapMeta = delayLine[5];
      end
   end

   // Normalise: product is in [1,4); a set top bit means shift right by one.
   always_comb begin
      lead = 1'b0;
      frac = '0;
      emax = 17'd255;
      case (tapMeta.fmt)
         2'd1: begin
            lead = R64[53];
            frac = lead ? {60'd0, R64[52:1]} : {60'd0, R64[51:0]};
            emax = 17'd2047;
         end
         2'd2: begin
            lead = R128[113];
            frac = lead ? R128[112:1] : R128[111:0];
            emax = 17'd32767;
         end
         default: begin
            lead = R32[24];
            frac = lead ? {89'd0, R32[23:1]} : {89'd0, R32[22:0]};
            emax = 17'd255;
         end
      endcase
   end

`ifdef FMUL_NORM_ROUND_EN
   logic         guard;
   logic [111:0] fracMask;

   // Guard exists only when the product was shifted right.
   always_comb begin
      guard    = 1'b0;
      fracMask = '0;
      case (tapMeta.fmt)
         2'd1: begin
            guard    = R64[53] & R64[0];
            fracMask = {60'd0, {52{1'b1}}};
         end
         2'd2: begin
            guard    = R128[113] & R128[0];
            fracMask = {112{1'b1}};
         end
         default: begin
            guard    = R32[24] & R32[0];
            fracMask = {89'd0, {23{1'b1}}};
         end
      endcase
      // Rounding an all-ones fraction up carries into the hidden bit:
      // mantissa becomes 2.0, i.e. fraction 0 with exponent + 1.
      fracCarry = guard & (frac == fracMask);
      fracOut   = fracCarry ? '0 : frac + {111'd0, guard};
   end
`else
   assign fracCarry = 1'b0;
   assign fracOut   = frac;
`endif

   assign expFinal = tapMeta.expSum + {16'd0, lead} + {16'd0, fracCarry};

   always_comb begin
      resE   = '0;
      resM   = '0;
      resOvf = 1'b0;
      resUnf = 1'b0;
      if (tapMeta.zero) begin
         resE = '0;
      end else if ($signed(expFinal) >= $signed(emax)) begin
         resE   = emax[14:0];
         resOvf = 1'b1;
      end else if ($signed(expFinal) <= 17'sd0) begin
         resUnf = 1'b1;
      end else begin
         resE = expFinal[14:0];
         resM = fracOut;
      end
   end

   // ---------------- result register ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         RDY  <= 1'b0;
         RFMT <= '0;
         RTAG <= '0;
         RS   <= 1'b0;
         RE   <= '0;
         RM   <= '0;
         OVF  <= 1'b0;
         UNF  <= 1'b0;
      end else begin
         RDY <= tapHit;
         if (tapHit) begin
            RFMT <= tapMeta.fmt;
            RTAG <= tapMeta.tag;
            RS   <= tapMeta.sign;
            RE   <= resE;
            RM   <= resM;
            OVF  <= resOvf;
            UNF  <= resUnf;
         end
      end
   end

endmodule

// File: tb/tb_fmul_norm.sv
// Bench for fmul_norm: directed scenarios plus randomized traffic, checked
// against an arithmetic reference model and a completion-cycle scoreboard.
module tb_fmul_norm;

   localparam int MAXC = 4096;

   logic         CLK;
   logic         RESET;
   logic         STB;
   logic         ACK;
   logic [1:0]   FMT;
   logic         SA, SB;
   logic [14:0]  EA, EB;
   logic         ZA, ZB;
   logic [5:0]   TAG;
   logic [24:0]  R32;
   logic [53:0]  R64;
   logic [113:0] R128;
   logic         RDY;
   logic [1:0]   RFMT;
   logic [5:0]   RTAG;
   logic         RS;
   logic [14:0]  RE;
   logic [111:0] RM;
   logic         OVF, UNF;

   fmul_norm dut (
      .CLK(CLK), .RESET(RESET), .STB(STB), .ACK(ACK), .FMT(FMT),
      .SA(SA), .SB(SB), .EA(EA), .EB(EB), .ZA(ZA), .ZB(ZB), .TAG(TAG),
      .R32(R32), .R64(R64), .R128(R128),
      .RDY(RDY), .RFMT(RFMT), .RTAG(RTAG), .RS(RS), .RE(RE), .RM(RM),
      .OVF(OVF), .UNF(UNF)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   typedef struct {
      int           due;
      logic [1:0]   fmt;
      logic [5:0]   tag;
      logic         s;
      logic [14:0]  e;
      logic [111:0] m;
      logic         ovf;
      logic         unf;
   } expRec_t;

   expRec_t      expQ [$];
   bit           busy [MAXC];     // product cycles already booked
   logic [113:0] prodAt [MAXC];   // product to drive in a given cycle
   int           cyc;
   bit           armed;
   int           checks;
   int           fails;

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      if (obs !== expv) begin
         fails++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   // Reference model: value-level arithmetic on the product integer.
   function automatic expRec_t model(input int dueC, input logic [1:0] fmt, input logic sa, input logic sb,
                                     input logic [14:0] ea, input logic [14:0] eb, input logic za,
                                     input logic zb, input logic [5:0] tag, input logic [113:0] prod);
      expRec_t r;
      int w, bias, emax, x, sh;
      logic [127:0] p, m, fmask;
      case (fmt)
         2'd0:    begin w = 25;  bias = 127;   emax = 255;   end
         2'd1:    begin w = 54;  bias = 1023;  emax = 2047;  end
         default: begin w = 114; bias = 16383; emax = 32767; end
      endcase
      p  = {14'd0, prod} & ((128'd1 << w) - 1);
      sh = int'(p[w-1]);
      x  = int'(ea) + int'(eb) - bias + sh;
`ifdef FMUL_NORM_ROUND_EN
      m = (p + 128'(sh)) >> sh;   // half-up rounding of p / 2^sh
`else
      m = p >> sh;
`endif
      if (m[w-1]) begin           // rounded up to 2.0
         m = m >> 1;
         x = x + 1;
      end
      fmask = (128'd1 << (w - 2)) - 1;
      r.due = dueC; r.fmt = fmt; r.tag = tag; r.s = sa ^ sb;
      r.e = '0; r.m = '0; r.ovf = 1'b0; r.unf = 1'b0;
      if (za || zb) begin
         r.e = '0;
      end else if (x >= emax) begin
         r.e = 15'(emax); r.ovf = 1'b1;
      end else if (x <= 0) begin
         r.unf = 1'b1;
      end else begin
         r.e = 15'(x);
         r.m = 112'(m & fmask);
      end
      return r;
   endfunction

   function automatic logic [113:0] randProd(input logic [1:0] fmt);
      logic [127:0] p;
      int w, sel;
      w   = (fmt == 2'd0) ? 25 : (fmt == 2'd1) ? 54 : 114;
      p   = {$urandom, $urandom, $urandom, $urandom};
      p   = p & ((128'd1 << w) - 1);
      sel = $urandom_range(0, 7);
      if (sel == 0)      p = (128'd1 << w) - 1;         // rounds to carry
      else if (sel == 1) p = (128'd1 << (w - 1)) - 1;   // lead clear, all ones
      else if (!p[w-1])  p[w-2] = 1'b1;
      return p[113:0];
   endfunction

   task automatic checkOutputs();
      bit      found;
      int      idx;
      expRec_t e;
      found = 0; idx = 0; e = '{default: 0};
      for (int i = 0; i < expQ.size(); i++)
         if (expQ[i].due == cyc) begin found = 1; idx = i; e = expQ[i]; end
      checkVal("rdy", RDY, found);
      if (found) begin
         checkVal("rfmt", RFMT, e.fmt);
         checkVal("rtag", RTAG, e.tag);
         checkVal("rs", RS, e.s);
         checkVal("re", RE, e.e);
         checkVal("rm", RM, e.m);
         checkVal("ovf", OVF, e.ovf);
         checkVal("unf", UNF, e.unf);
         expQ.delete(idx);
      end
   endtask

   // One clock cycle: check registered outputs, apply inputs, check ACK.
   task automatic doCycle(input logic rst, input logic stb, input logic [1:0] fmt, input logic sa,
                          input logic sb, input logic [14:0] ea, input logic [14:0] eb, input logic za,
                          input logic zb, input logic [5:0] tag, input logic [113:0] prod);
      int   lat;
      logic modelAck;
      @(negedge CLK);
      cyc++;
      if (armed) checkOutputs();
      RESET = rst; STB = stb; FMT = fmt; SA = sa; SB = sb;
      EA = ea; EB = eb; ZA = za; ZB = zb; TAG = tag;
      R32 = prodAt[cyc][24:0]; R64 = prodAt[cyc][53:0]; R128 = prodAt[cyc];
      #1;
      lat = (fmt == 2'd0) ? 2 : (fmt == 2'd1) ? 3 : 6;
      if (rst) begin
         for (int i = cyc; i < MAXC; i++) busy[i] = 0;
         expQ.delete();
      end else begin
         modelAck = (fmt != 2'd3) && !busy[cyc + lat];
         checkVal("ack", ACK, modelAck);
         if (stb && modelAck) begin
            busy[cyc + lat]   = 1;
            prodAt[cyc + lat] = prod;
            expQ.push_back(model(cyc + lat + 1, fmt, sa, sb, ea, eb, za, zb, tag, prod));
         end
      end
   endtask

   task automatic doIdle(input int n);
      for (int i = 0; i < n; i++) doCycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic doReset();
      doCycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic doRandom(input logic [1:0] fmt);
      int bias;
      bias = (fmt == 2'd0) ? 127 : (fmt == 2'd1) ? 1023 : 16383;
      doCycle(1'b0, 1'b1, fmt, 1'($urandom), 1'($urandom),
              15'($urandom_range(2 * bias, 1)), 15'($urandom_range(2 * bias, 1)),
              ($urandom_range(0, 7) == 0), 1'b0, 6'($urandom_range(0, 63)), randProd(fmt));
   endtask

   initial begin
      logic [1:0] f;
      checks = 0; fails = 0; cyc = 0; armed = 0;
      RESET = 1'b1; STB = 1'b0; FMT = '0; SA = 0; SB = 0; EA = '0; EB = '0;
      ZA = 0; ZB = 0; TAG = '0; R32 = '0; R64 = '0; R128 = '0;
      for (int i = 0; i < MAXC; i++) begin busy[i] = 0; prodAt[i] = '0; end

      doReset();
      doReset();
      armed = 1;
      doIdle(1);
      checkVal("rst_rdy", RDY, 0);
      checkVal("rst_re", RE, 0);
      checkVal("rst_rm", RM, 0);
      checkVal("rst_rs", RS, 0);
      checkVal("rst_rtag", RTAG, 0);
      checkVal("rst_rfmt", RFMT, 0);
      checkVal("rst_ovf", OVF, 0);
      checkVal("rst_unf", UNF, 0);
      checkVal("rst_ack", ACK, 1);

      // 1.5 * 1.5 single
      doCycle(0, 1, 2'd0, 0, 0, 15'd127, 15'd127, 0, 0, 6'd1, 114'h1200000);
      doIdle(3);
      checkVal("sq_rdy", RDY, 1);
      checkVal("sq_re", RE, 128);
      checkVal("sq_rm", RM, 112'h100000);
      checkVal("sq_ovf", OVF, 0);

      // double max normal * 2.0 overflows
      doIdle(4);
      doCycle(0, 1, 2'd1, 0, 0, 15'd2046, 15'd1024, 0, 0, 6'd2, {60'd0, 2'b01, {52{1'b1}}});
      doIdle(4);
      checkVal("ovf_flag", OVF, 1);
      checkVal("ovf_re", RE, 2047);
      checkVal("ovf_rm", RM, 0);

      // quad at t0 blocks a single at t0+4; retry at t0+5
      doIdle(8);
      doCycle(0, 1, 2'd2, 0, 1, 15'd16383, 15'd16390, 0, 0, 6'd10, randProd(2'd2));
      doIdle(3);
      doCycle(0, 1, 2'd0, 1, 1, 15'd130, 15'd100, 0, 0, 6'd11, 114'h1555555);
      checkVal("conflict_ack", ACK, 0);
      doCycle(0, 1, 2'd0, 1, 1, 15'd130, 15'd100, 0, 0, 6'd11, 114'h1555555);
      checkVal("retry_ack", ACK, 1);
      doIdle(2);
      checkVal("quad_rdy", RDY, 1);
      checkVal("quad_tag", RTAG, 10);
      doIdle(1);
      checkVal("single_rdy", RDY, 1);
      checkVal("single_tag", RTAG, 11);

      // all-ones fractions: no guard, then guard with carry
      doIdle(8);
      doCycle(0, 1, 2'd0, 0, 0, 15'd127, 15'd127, 0, 0, 6'd30, 114'h0FFFFFF);
      doCycle(0, 1, 2'd0, 0, 0, 15'd127, 15'd127, 0, 0, 6'd31, 114'h1FFFFFF);
      doIdle(2);
      checkVal("ones_rm", RM, 112'h7FFFFF);
      checkVal("ones_re", RE, 127);
      doIdle(1);
`ifdef FMUL_NORM_ROUND_EN
      checkVal("carry_rm", RM, 0);
      checkVal("carry_re", RE, 129);
`else
      checkVal("trunc_rm", RM, 112'h7FFFFF);
      checkVal("trunc_re", RE, 128);
`endif

      // zero operand keeps the product sign
      doIdle(8);
      doCycle(0, 1, 2'd1, 1, 0, 15'd1500, 15'd900, 1, 0, 6'd40, randProd(2'd1));
      doIdle(4);
      checkVal("zero_rs", RS, 1);
      checkVal("zero_re", RE, 0);
      checkVal("zero_rm", RM, 0);
      checkVal("zero_ovf", OVF, 0);
      checkVal("zero_unf", UNF, 0);

      // reset drops an in-flight quad; a single issued after completes
      doIdle(8);
      doCycle(0, 1, 2'd2, 0, 0, 15'd16383, 15'd16383, 0, 0, 6'd20, randProd(2'd2));
      doIdle(2);
      doReset();
      doCycle(0, 1, 2'd0, 0, 1, 15'd127, 15'd128, 0, 0, 6'd21, randProd(2'd0));
      checkVal("post_rst_ack", ACK, 1);
      doIdle(3);
      checkVal("post_rst_rdy", RDY, 1);
      checkVal("post_rst_tag", RTAG, 21);

      // back-to-back singles
      doIdle(8);
      for (int i = 0; i < 40; i++) doRandom(2'd0);

      // random mixed traffic
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 199) == 0) doReset();
         else if ($urandom_range(0, 3) == 0) doIdle(1);
         else begin
            f = 2'($urandom_range(0, 3));
            doRandom(f);
         end
      end

      doIdle(10);
      checkVal("drain", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
